// File: rtl/osc_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// osc_capture_ctrl_if
// Bundles the two buses owned by the capture sequencer:
//   - readout stream : rd_data, rd_valid, rd_last (to consumer), rd_ready (from consumer)
//   - RAM port       : bram_en, bram_we, bram_addr, bram_di (to RAM), bram_do (from RAM)
// Handshake semantics of the readout stream: a beat transfers on every rising
// clock edge where rd_valid && rd_ready. Once rd_valid is raised, rd_data and
// rd_last stay constant until that transfer; rd_valid never depends on
// rd_ready, while rd_ready may depend on rd_valid.
// Modports: master = sequencer side, slave = consumer/RAM side.
// ---------------------------------------------------------------------------
interface osc_capture_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di;
  logic [DATA_W-1:0] bram_do;

  modport master (
    output rd_data, rd_valid, rd_last, bram_en, bram_we, bram_addr, bram_di,
    input  rd_ready, bram_do
  );

  modport slave (
    input  rd_data, rd_valid, rd_last, bram_en, bram_we, bram_addr, bram_di,
    output rd_ready, bram_do
  );
endinterface

// File: rtl/osc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// osc_capture_ctrl
// Capture/readout sequencer for the oscilloscope sample buffer. Sole owner of
// a single-port RAM (1-cycle read latency). Samples are written circularly;
// after pre-trigger fill a level/slope trigger is searched, the post-trigger
// part is filled, then the whole frame is streamed out oldest-first.
//
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   arm                 start pulse (accepted only in IDLE)
//   pretrig_len         pre-trigger sample count (latched on arm)
//   trig_level          unsigned threshold (latched on arm)
//   trig_slope          0 = rising, 1 = falling (latched on arm)
//   sample_in/_valid    ADC sample stream
//   busy                state != IDLE
//   triggered           trigger seen, until return to IDLE
//   done                1-cycle pulse after the final readout beat
//   dbg_state           current FSM state encoding
//   bus                 readout stream + RAM port (osc_capture_ctrl_if.master)
//
// Optional feature macro: AUTO_TRIG_EN
//   adds auto_timeout[15:0] (latched on arm) and auto_trig output; forces a
//   trigger in ARMED after auto_timeout cycles (0 disables it).
// ---------------------------------------------------------------------------
module osc_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              arm,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
`ifdef AUTO_TRIG_EN
  input  logic [15:0]       auto_timeout,
  output logic              auto_trig,
`endif
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [2:0]        dbg_state,
  osc_capture_ctrl_if.master bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, r_cnt, r_pretrig, r_post_cnt, r_rd_addr, r_sent;
  logic [ADDR_W:0]   r_issued;
  logic [DATA_W-1:0] r_level, r_prev, r_skid0, r_skid1;
  logic              r_slope, r_prev_vld, r_triggered, r_done, r_inflight;
  logic [1:0]        r_skid_cnt;

  logic              w_capture, w_wr, w_level_hit, w_force, w_trig;
  logic              w_pop, w_issue, w_last, w_rd_valid;
  logic [2:0]        w_occ;
  logic [ADDR_W-1:0] w_post_init;

`ifdef AUTO_TRIG_EN
  logic [15:0] r_timeout, r_auto_cnt;
  logic        r_auto_trig;
  assign w_force   = (r_timeout != 16'd0) && (r_auto_cnt >= r_timeout);
  assign auto_trig = r_auto_trig;
`else
  assign w_force = 1'b0;
`endif

  assign w_capture = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_wr      = w_capture && sample_valid;

  // A level crossing needs a real previous sample; with pretrig_len==0 the
  // very first ARMED sample has nothing to compare against.
  assign w_level_hit = r_prev_vld &&
                       (r_slope ? ((r_prev > r_level) && (sample_in <= r_level))
                                : ((r_prev < r_level) && (sample_in >= r_level)));
  assign w_trig = (r_state == S_ARMED) && sample_valid && (w_level_hit || w_force);

  // Samples still to be written after the trigger sample.
  assign w_post_init = {ADDR_W{1'b1}} - r_pretrig;

  assign w_rd_valid = (r_skid_cnt != 2'd0);
  assign w_pop      = w_rd_valid && bus.rd_ready;
  assign w_last     = (r_sent == {ADDR_W{1'b1}});

  // Skid occupancy once this cycle's pop is taken into account, plus the read
  // already in flight. Counting the pop lets a read go out every cycle while
  // the consumer keeps rd_ready high, yet never more than two words pending.
  assign w_occ   = {1'b0, r_skid_cnt} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_issue = (r_state == S_READ) && (r_issued != (ADDR_W+1)'(DEPTH)) &&
                   (w_occ < 3'd2);

  // Next state and outputs.
  always_comb begin
    w_state_nxt   = r_state;
    bus.bram_en   = 1'b0;
    bus.bram_we   = 1'b0;
    bus.bram_addr = '0;
    bus.bram_di   = '0;
    bus.rd_valid  = w_rd_valid;
    bus.rd_data   = r_skid0;
    bus.rd_last   = w_rd_valid && w_last;

    if (w_wr) begin
      bus.bram_en   = 1'b1;
      bus.bram_we   = 1'b1;
      bus.bram_addr = r_wr_ptr;
      bus.bram_di   = sample_in;
    end else if (w_issue) begin
      bus.bram_en   = 1'b1;
      bus.bram_addr = r_rd_addr;
    end

    case (r_state)
      S_IDLE:  if (arm) w_state_nxt = (pretrig_len == '0) ? S_ARMED : S_PRE;
      S_PRE:   if (w_wr && ((r_cnt + ADDR_W'(1)) == r_pretrig)) w_state_nxt = S_ARMED;
      S_ARMED: if (w_trig) w_state_nxt = (w_post_init == '0) ? S_READ : S_POST;
      S_POST:  if (w_wr && (r_post_cnt == ADDR_W'(1))) w_state_nxt = S_READ;
      S_READ:  if (w_pop && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_pretrig   <= '0;
      r_post_cnt  <= '0;
      r_rd_addr   <= '0;
      r_sent      <= '0;
      r_issued    <= '0;
      r_level     <= '0;
      r_prev      <= '0;
      r_slope     <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_inflight  <= 1'b0;
      r_skid0     <= '0;
      r_skid1     <= '0;
      r_skid_cnt  <= 2'd0;
`ifdef AUTO_TRIG_EN
      r_timeout   <= '0;
      r_auto_cnt  <= '0;
      r_auto_trig <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= 1'b0;
      r_inflight <= w_issue;

      if ((r_state == S_IDLE) && arm) begin
        // pretrig_len is ADDR_W bits wide, so it can never exceed DEPTH-1:
        // the clamp is implicit in the port width.
        r_pretrig  <= pretrig_len;
        r_level    <= trig_level;
        r_slope    <= trig_slope;
        r_wr_ptr   <= '0;
        r_cnt      <= '0;
        r_prev_vld <= 1'b0;
        r_issued   <= '0;
        r_sent     <= '0;
`ifdef AUTO_TRIG_EN
        r_timeout  <= auto_timeout;
        r_auto_cnt <= '0;
`endif
      end

`ifdef AUTO_TRIG_EN
      // Only counts while ARMED; it was zeroed on arm, so PRE->ARMED starts at 0.
      if ((r_state == S_ARMED) && (r_auto_cnt != 16'hFFFF))
        r_auto_cnt <= r_auto_cnt + 16'd1;
`endif

      if (w_wr) begin
        r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
        r_prev     <= sample_in;
        r_prev_vld <= 1'b1;
        if (r_state == S_PRE)  r_cnt      <= r_cnt + ADDR_W'(1);
        if (r_state == S_POST) r_post_cnt <= r_post_cnt - ADDR_W'(1);
      end

      if (w_trig) begin
        r_triggered <= 1'b1;
        r_post_cnt  <= w_post_init;
        // Oldest sample of the frame: trigger address minus the pre-trigger
        // length, wrapping naturally in ADDR_W bits.
        r_rd_addr   <= r_wr_ptr - r_pretrig;
`ifdef AUTO_TRIG_EN
        r_auto_trig <= !w_level_hit;
`endif
      end

      if (w_issue) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
        r_issued  <= r_issued + (ADDR_W+1)'(1);
      end

      // Two-entry skid: r_skid0 is the head, RAM data lands one cycle after
      // the read was issued (r_inflight).
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_skid_cnt == 2'd0) r_skid0 <= bus.bram_do;
          else                    r_skid1 <= bus.bram_do;
          r_skid_cnt <= r_skid_cnt + 2'd1;
        end
        2'b01: begin
          r_skid0    <= r_skid1;
          r_skid_cnt <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid0 <= bus.bram_do;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= bus.bram_do;
          end
        end
        default: ;
      endcase

      if (w_pop) begin
        r_sent <= r_sent + ADDR_W'(1);
        if (w_last) begin
          r_triggered <= 1'b0;
          r_done      <= 1'b1;
`ifdef AUTO_TRIG_EN
          r_auto_trig <= 1'b0;
`endif
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign triggered = r_triggered;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_osc_capture_ctrl.sv
module tb_osc_capture_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic              arm, trig_slope, sample_valid;
  logic [ADDR_W-1:0] pretrig_len;
  logic [DATA_W-1:0] trig_level, sample_in;
  logic              busy, triggered, done;
  logic [2:0]        dbg_state;
`ifdef AUTO_TRIG_EN
  logic [15:0]       auto_timeout;
  logic              auto_trig;
`endif

  osc_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  osc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .arm          (arm),
    .pretrig_len  (pretrig_len),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
`ifdef AUTO_TRIG_EN
    .auto_timeout (auto_timeout),
    .auto_trig    (auto_trig),
`endif
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .dbg_state    (dbg_state),
    .bus          (bus)
  );

  // RAM model: 1-cycle read latency
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_di;
      else             bus.bram_do <= mem[bus.bram_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: sample stream of the current capture and expected readout
  logic [DATA_W-1:0] smp[$];
  logic [DATA_W-1:0] exp_q[$];

  function automatic bit level_hit(int i, logic [7:0] lvl, bit slope);
    if (i < 1) return 1'b0;
    if (!slope) return (smp[i-1] < lvl) && (smp[i] >= lvl);
    return (smp[i-1] > lvl) && (smp[i] <= lvl);
  endfunction

  // index of the trigger sample; timeout counts samples in ARMED (continuous feed)
  function automatic int find_trig(int pre, logic [7:0] lvl, bit slope, int tmo);
    for (int i = pre; i < smp.size(); i++) begin
      if (level_hit(i, lvl, slope)) return i;
      if ((tmo != 0) && ((i - pre) >= tmo)) return i;
    end
    return -1;
  endfunction

  // readout consumer
  int ready_mode = 0;
  int ready_k = 0;
  initial begin
    bus.rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) bus.rd_ready = 1'b1;
      else begin
        case (ready_k % 4)
          0: bus.rd_ready = 1'b1;
          1: bus.rd_ready = 1'b0;
          2: bus.rd_ready = 1'b0;
          default: bus.rd_ready = 1'($urandom_range(0, 1));
        endcase
        ready_k++;
      end
    end
  end

  // scoreboard / compare process for the readout stream
  bit                cmp_en = 0;
  bit                done_due = 0;
  bit                frame_done = 0;
  bit                hold_v = 0;
  logic [DATA_W-1:0] hold_d;
  logic [DATA_W-1:0] e;
  always @(negedge clk) begin
    if (cmp_en) begin
      if (done_due) begin
        check("done_pulse", done, 1);
        check("idle_busy", busy, 0);
        check("trig_cleared", triggered, 0);
        done_due = 0;
        frame_done = 1;
      end else begin
        check("done_low", done, 0);
      end
      if (hold_v) begin
        check("stall_valid", bus.rd_valid, 1);
        check("stall_data", bus.rd_data, hold_d);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", bus.rd_data, e);
          check("rd_last", bus.rd_last, (exp_q.size() == 0));
          if (exp_q.size() == 0) done_due = 1;
        end
      end
      hold_v = bus.rd_valid && !bus.rd_ready;
      hold_d = bus.rd_data;
    end
  end

  // driver: one full capture + readout
  task automatic run_capture(input int pre, input logic [7:0] lvl, input bit slope,
                             input int tmo, input bit gaps, input int rmode,
                             input bit arm_in_pre, input bit arm_in_read);
    int t, post, total;
    t = find_trig(pre, lvl, slope, tmo);
    check("model_trig_found", (t >= 0), 1);
    if (t < 0) return;
    post  = DEPTH - 1 - pre;
    total = t + post + 1;
    exp_q.delete();
    for (int k = t - pre; k <= t + post; k++) exp_q.push_back(smp[k]);
    ready_mode = rmode; ready_k = 0;
    frame_done = 0; done_due = 0; hold_v = 0;
    cmp_en = 1;

    @(posedge clk); #1;
    arm = 1; pretrig_len = ADDR_W'(pre); trig_level = lvl; trig_slope = slope;
`ifdef AUTO_TRIG_EN
    auto_timeout = 16'(tmo);
`endif
    @(posedge clk); #1;
    arm = 0;
    // configuration must be latched: scramble inputs afterwards
    pretrig_len = ADDR_W'($urandom_range(0, DEPTH - 1));
    trig_level  = 8'($urandom_range(0, 255));
    trig_slope  = 1'($urandom_range(0, 1));

    for (int i = 0; i < total; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        sample_valid = 0;
        @(negedge clk);
        check("gap_no_write", bus.bram_we, 0);
        check("gap_triggered", triggered, (i > t));
        @(posedge clk); #1;
      end
      sample_valid = 1; sample_in = smp[i];
      if (arm_in_pre && i == 1) begin arm = 1; pretrig_len = '0; end
      @(negedge clk);
      check("wr_we", bus.bram_we, 1);
      check("wr_addr", bus.bram_addr, i % DEPTH);
      check("wr_data", bus.bram_di, smp[i]);
      check("cap_busy", busy, 1);
      check("cap_triggered", triggered, (i > t));
      @(posedge clk); #1;
      arm = 0;
    end
    sample_valid = 0;
    @(negedge clk);
    check("read_lat0", bus.rd_valid, 0);
    check("read_triggered", triggered, 1);
`ifdef AUTO_TRIG_EN
    check("auto_trig", auto_trig, (tmo != 0) && !level_hit(t, lvl, slope));
`endif
    @(negedge clk);
    check("read_lat1", bus.rd_valid, 0);
    @(negedge clk);
    check("read_lat2", bus.rd_valid, 1);

    for (int k = 0; k < 400 && !frame_done; k++) begin
      @(posedge clk); #1;
      arm = (arm_in_read && k == 3);
      if (arm_in_read && k == 4) begin
        @(negedge clk);
        check("arm_read_ignored", busy, 1);
      end
    end
    arm = 0;
    check("frame_complete", frame_done, 1);
    check("all_beats", exp_q.size(), 0);
    cmp_en = 0;
    @(negedge clk);
    check("post_idle", busy, 0);
  endtask

  initial begin
    int t;
    rst_n = 0; arm = 0; pretrig_len = '0; trig_level = '0; trig_slope = 0;
    sample_in = '0; sample_valid = 0;
`ifdef AUTO_TRIG_EN
    auto_timeout = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_bram_en", bus.bram_en, 0);
    check("rst_bram_we", bus.bram_we, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // 1: ramp, pre=4, rising 0x80
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back(8'(i * 16));
    t = find_trig(4, 8'h80, 0, 0);
    check("pin_t1_idx", t, 8);
    check("pin_t1_first", smp[t - 4], 8'h40);
    check("pin_t1_last", smp[t + 11], 8'h30);
    run_capture(4, 8'h80, 0, 0, 0, 0, 0, 0);

    // 2: pre=0, falling 0x20, first sample has no predecessor
    smp.delete();
    smp.push_back(8'h10); smp.push_back(8'h30); smp.push_back(8'h20);
    for (int i = 0; i < 15; i++) smp.push_back(8'(8'h40 + i));
    t = find_trig(0, 8'h20, 1, 0);
    check("pin_t2_idx", t, 2);
    run_capture(0, 8'h20, 1, 0, 1, 0, 0, 0);

    // 3: buffer wraps 3 times while ARMED
    smp.delete();
    for (int i = 0; i < 52; i++) smp.push_back(8'(i));
    smp.push_back(8'h80);
    for (int i = 0; i < 11; i++) smp.push_back(8'(8'h91 + i));
    t = find_trig(4, 8'h80, 0, 0);
    check("pin_t3_idx", t, 52);
    check("pin_t3_first", smp[t - 4], 8'h30);
    run_capture(4, 8'h80, 0, 0, 0, 0, 0, 0);

    // 4: stalled consumer + arm during PRE
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back(8'(i * 16 + 3));
    run_capture(4, 8'h80, 0, 0, 1, 1, 1, 0);

    // 5: reset mid-POST
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back(8'(i * 16));
    @(posedge clk); #1;
    arm = 1; pretrig_len = 4; trig_level = 8'h80; trig_slope = 0;
    @(posedge clk); #1;
    arm = 0;
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1; sample_in = smp[i];
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("post_busy", busy, 1);
    check("post_triggered", triggered, 1);
    @(posedge clk); #1;
    rst_n = 0; sample_in = 8'h55;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_we", bus.bram_we, 0);
    check("rst_mid_trig", triggered, 0);
    check("rst_mid_valid", bus.rd_valid, 0);
    sample_valid = 0;

    // 5b: fresh capture after reset, falling, arm pulsed during READ
    smp.delete();
    for (int i = 0; i < 18; i++) smp.push_back(8'(8'hFF - 16 * i));
    t = find_trig(2, 8'hC0, 1, 0);
    check("pin_t5_idx", t, 4);
    run_capture(2, 8'hC0, 1, 0, 0, 0, 0, 1);

    // 6: pre=DEPTH-1, no post samples
    smp.delete();
    for (int i = 0; i < 15; i++) smp.push_back(8'(i));
    smp.push_back(8'h80);
    t = find_trig(15, 8'h80, 0, 0);
    check("pin_t6_idx", t, 15);
    run_capture(15, 8'h80, 0, 0, 0, 0, 0, 0);

`ifdef AUTO_TRIG_EN
    // 7: forced trigger on flat input
    smp.delete();
    for (int i = 0; i < 21; i++) smp.push_back(8'h00);
    t = find_trig(0, 8'h80, 0, 5);
    check("pin_t7_idx", t, 5);
    run_capture(0, 8'h80, 0, 5, 0, 0, 0, 0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
